decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Pipelined successor to the single-cycle decode block. It decodes an IF/ID instruction using the team's existing control_unit and sign_extend decoders.
- Contains a parametrised register file with write-through bypass.
- Registers all decoded fields into an ID/EX output register under a valid/ready handshake.
- Detects load-use hazards against the instruction held in its own output register, inserts one bubble per hazard, and supports flush from branch resolution.

Parameters:
DATA_WIDTH, 32, width of instructions, register data, immediates and PC.
REG_COUNT, 32, number of architectural registers; address width RA_W = $clog2(REG_COUNT), power of two, 2..32.
A0_IDX, 10, register index mirrored on the a0 debug output.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  IF/ID holds a valid instruction
in_ready  output  1  stage accepts instr/pc_in this cycle
instr  input  DATA_WIDTH  instruction word
pc_in  input  DATA_WIDTH  PC of instr
flush  input  1  discard output register contents and the current input
wb_en  input  1  register write enable from writeback
wb_addr  input  RA_W  write register index
wb_data  input  DATA_WIDTH  write data
ex_ready  input  1  EX stage consumes output register this cycle
out_valid  output  1  output register holds a valid decoded instruction
ALUctrl  output  3  registered control_unit field
ALUSrc, MemWrite, Branch, Jump, branch_neg, PcOp, RegWrite  output  1 each  registered control bits
ResultSrc  output  2  registered; 2'b01 = load
ImmExt  output  DATA_WIDTH  registered extended immediate
rd1, rd2  output  DATA_WIDTH  registered operand values
rs1_addr, rs2_addr, rd_addr  output  RA_W  registered instr[19:15], [24:20], [11:7] (low RA_W bits)
pc_out  output  DATA_WIDTH  registered pc_in
a0  output  DATA_WIDTH  combinational view of register A0_IDX

Behaviour:
- Reset:
  - All registers clear to 0.
  - out_valid=0; every registered output=0; a0=0 after the reset edge.
  - Reset overrides flush and writeback in the same cycle.
- Register file:
  - Write at clk edge when wb_en && wb_addr!=0.
  - Register 0 always reads 0 and is never written.
  - Reads are combinational with write-through: if wb_en && wb_addr!=0 && wb_addr==read index, wb_data is returned in the same cycle.
- Uses: rs1/rs2 are treated as used unless opcode instr[6:0] is 0110111, 0010111 or 1101111 (LUI/AUIPC/JAL).
- Hazard: hazard = out_valid && ResultSrc==2'b01 && rd_addr!=0 && in_valid && ((rd_addr==rs1 && uses) || (rd_addr==rs2 && uses)).
- Output register advance: advance = !out_valid || ex_ready.
- in_ready = flush || (advance && !hazard).
- Per-edge priority (rst excluded):
  1. flush: out_valid<=0; the input is consumed and discarded; no other output fields need to change.
  2. advance && hazard: bubble, out_valid<=0. The input is not consumed and is re-evaluated next cycle, so exactly one bubble is inserted per load-use pair.
  3. advance && in_valid: capture decoded fields, operand reads (with bypass), pc_in; out_valid<=1.
  4. advance && !in_valid: out_valid<=0.
  5. otherwise (stalled by EX): hold all outputs.
- Latency: 1 cycle from accepted instruction to out_valid.
- Throughput: 1 instruction per cycle with no hazard and ex_ready=1.
- Stall hold: while out_valid && !ex_ready, all registered outputs stay stable. The held rd1/rd2 are NOT refreshed by later writebacks; forwarding in EX covers this.
- Writeback: performed regardless of stall or flush state.

Test Plan:
- rst high 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1 after release; a0=0.
- wb x5=0xDEADBEEF in the same cycle as accepting instr 0x00528533 (add x10,x5,x5) -> next cycle out_valid=1, rd1=rd2=0xDEADBEEF, rd_addr=10, RegWrite=1. A later wb x10=0x1234 -> a0=0x1234.
- Load-use: accept lw x6,0(x1) (0x0000A303), then present add x7,x6,x2 (0x002303B3) with ex_ready=1 -> in_ready=0 for 1 cycle, out_valid=0 for 1 cycle (bubble), add issued the following cycle. Same scenario with rd=x0 -> no bubble.
- EX stall: out_valid=1, ex_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged for all 3 cycles; ex_ready=1 -> next instruction captured on the following edge.
- Flush while out_valid=1, ex_ready=0, in_valid=1 -> in_ready=1 that cycle, out_valid=0 next cycle, input instruction never appears at the output.
- wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, then decode add x1,x0,x0 -> rd1=rd2=0. Repeat with REG_COUNT=16: wb x15, read back via rs1=x15 correct.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Pipelined instruction decode stage: register file with write-through bypass,
// ID/EX output register with valid/ready handshake, load-use bubble and flush.

module control_unit (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] ALUctrl,
   output logic       ALUSrc,
   output logic       MemWrite,
   output logic       Branch,
   output logic       Jump,
   output logic       branch_neg,
   output logic       PcOp,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc
);
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   logic [2:0] alu_funct;
   logic       is_rtype;

   assign is_rtype = (opcode == 7'b0110011);

   // Subtraction only exists in the register-register form; addi never subtracts.
   always_comb begin
      alu_funct = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_funct = ALU_SLL;
         3'b010:  alu_funct = ALU_SLT;
         3'b011:  alu_funct = ALU_SLT;
         3'b100:  alu_funct = ALU_XOR;
         3'b101:  alu_funct = ALU_SRL;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
   end

   always_comb begin
      ALUctrl    = ALU_ADD;
      ALUSrc     = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 1'b0;
      Jump       = 1'b0;
      branch_neg = 1'b0;
      PcOp       = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ImmSrc     = 3'd0;
      case (opcode)
         7'b0110011: begin
            RegWrite = 1'b1;
            ALUctrl  = alu_funct;
         end
         7'b0010011: begin
            RegWrite = 1'b1;
            ALUSrc   = 1'b1;
            ALUctrl  = alu_funct;
         end
         7'b0000011: begin
            RegWrite  = 1'b1;
            ALUSrc    = 1'b1;
            ResultSrc = 2'b01;
         end
         7'b0100011: begin
            MemWrite = 1'b1;
            ALUSrc   = 1'b1;
            ImmSrc   = 3'd1;
         end
         7'b1100011: begin
            Branch     = 1'b1;
            ALUctrl    = ALU_SUB;
            branch_neg = funct3[0];
            ImmSrc     = 3'd2;
         end
         7'b1101111: begin
            Jump      = 1'b1;
            RegWrite  = 1'b1;
            ResultSrc = 2'b10;
            ImmSrc    = 3'd3;
         end
         7'b1100111: begin
            Jump      = 1'b1;
            RegWrite  = 1'b1;
            ALUSrc    = 1'b1;
            PcOp      = 1'b1;
            ResultSrc = 2'b10;
         end
         7'b0110111: begin
            RegWrite  = 1'b1;
            ResultSrc = 2'b11;
            ImmSrc    = 3'd4;
         end
         7'b0010111: begin
            RegWrite  = 1'b1;
            PcOp      = 1'b1;
            ResultSrc = 2'b11;
            ImmSrc    = 3'd4;
         end
         default: ;
      endcase
   end
endmodule

module sign_extend #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:7]           instr,
   input  logic [2:0]            ImmSrc,
   output logic [DATA_WIDTH-1:0] ImmExt
);
   logic [31:0] imm32;

   always_comb begin
      imm32 = {{20{instr[31]}}, instr[31:20]};
      case (ImmSrc)
         3'd1:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         3'd2:    imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         3'd3:    imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         3'd4:    imm32 = {instr[31:12], 12'b0};
         default: imm32 = {{20{instr[31]}}, instr[31:20]};
      endcase
   end

   assign ImmExt = DATA_WIDTH'($signed(imm32));
endmodule

module decode_stage_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int A0_IDX     = 10,
   localparam int RA_W      = $clog2(REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic [DATA_WIDTH-1:0] pc_in,
   input  logic                  flush,
   input  logic                  wb_en,
   input  logic [RA_W-1:0]       wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  ex_ready,
   output logic                  out_valid,
   output logic [2:0]            ALUctrl,
   output logic                  ALUSrc,
   output logic                  MemWrite,
   output logic                  Branch,
   output logic                  Jump,
   output logic                  branch_neg,
   output logic                  PcOp,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [DATA_WIDTH-1:0] ImmExt,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2,
   output logic [RA_W-1:0]       rs1_addr,
   output logic [RA_W-1:0]       rs2_addr,
   output logic [RA_W-1:0]       rd_addr,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] a0
);
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic                  wb_we;
   logic [RA_W-1:0]       rs_idx  [2];
   logic [DATA_WIDTH-1:0] rd_val  [2];
   logic [RA_W-1:0]       rd_idx;
   logic [6:0]            opcode;
   logic                  uses;
   logic                  hazard;
   logic                  advance;

   logic [2:0]            dec_alu;
   logic                  dec_alu_src, dec_mem_write, dec_branch, dec_jump;
   logic                  dec_branch_neg, dec_pc_op, dec_reg_write;
   logic [1:0]            dec_result_src;
   logic [2:0]            dec_imm_src;
   logic [DATA_WIDTH-1:0] dec_imm;

   assign opcode    = instr[6:0];
   assign rs_idx[0] = instr[15 +: RA_W];
   assign rs_idx[1] = instr[20 +: RA_W];
   assign rd_idx    = instr[7 +: RA_W];

   control_unit u_ctrl (
      .opcode     (opcode),
      .funct3     (instr[14:12]),
      .funct7b5   (instr[30]),
      .ALUctrl    (dec_alu),
      .ALUSrc     (dec_alu_src),
      .MemWrite   (dec_mem_write),
      .Branch     (dec_branch),
      .Jump       (dec_jump),
      .branch_neg (dec_branch_neg),
      .PcOp       (dec_pc_op),
      .RegWrite   (dec_reg_write),
      .ResultSrc  (dec_result_src),
      .ImmSrc     (dec_imm_src)
   );

   sign_extend #(.DATA_WIDTH(DATA_WIDTH)) u_sext (
      .instr  (instr[31:7]),
      .ImmSrc (dec_imm_src),
      .ImmExt (dec_imm)
   );

   // x0 is excluded from writes, so regs[0] stays at its reset value of zero.
   assign wb_we = wb_en && (wb_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_we) begin
         regs[wb_addr] <= wb_data;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_read
         assign rd_val[gi] = (wb_we && (wb_addr == rs_idx[gi])) ? wb_data : regs[rs_idx[gi]];
      end
   endgenerate

   assign a0 = regs[RA_W'(A0_IDX)];

   assign uses = !((opcode == 7'b0110111) || (opcode == 7'b0010111) || (opcode == 7'b1101111));

   // Compare against the load currently held in the output register.
   assign hazard = out_valid && (ResultSrc == 2'b01) && (rd_addr != '0) && in_valid &&
                   (((rd_addr == rs_idx[0]) && uses) || ((rd_addr == rs_idx[1]) && uses));

   assign advance  = !out_valid || ex_ready;
   assign in_ready = flush || (advance && !hazard);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         ALUctrl    <= '0;
         ALUSrc     <= 1'b0;
         MemWrite   <= 1'b0;
         Branch     <= 1'b0;
         Jump       <= 1'b0;
         branch_neg <= 1'b0;
         PcOp       <= 1'b0;
         RegWrite   <= 1'b0;
         ResultSrc  <= '0;
         ImmExt     <= '0;
         rd1        <= '0;
         rd2        <= '0;
         rs1_addr   <= '0;
         rs2_addr   <= '0;
         rd_addr    <= '0;
         pc_out     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         if (hazard || !in_valid) begin
            out_valid <= 1'b0;
         end else begin
            out_valid  <= 1'b1;
            ALUctrl    <= dec_alu;
            ALUSrc     <= dec_alu_src;
            MemWrite   <= dec_mem_write;
            Branch     <= dec_branch;
            Jump       <= dec_jump;
            branch_neg <= dec_branch_neg;
            PcOp       <= dec_pc_op;
            RegWrite   <= dec_reg_write;
            ResultSrc  <= dec_result_src;
            ImmExt     <= dec_imm;
            rd1        <= rd_val[0];
            rd2        <= rd_val[1];
            rs1_addr   <= rs_idx[0];
            rs2_addr   <= rs_idx[1];
            rd_addr    <= rd_idx;
            pc_out     <= pc_in;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: decode vector table plus hand-written
// sequences for load-use bubbles, EX stalls, flush, x0 writes and a 16-entry file.

module tb_decode_stage_pipe;
   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, flush, wb_en, ex_ready, out_valid;
   logic [31:0] instr, pc_in, wb_data;
   logic [4:0]  wb_addr;
   logic [2:0]  ALUctrl;
   logic        ALUSrc, MemWrite, Branch, Jump, branch_neg, PcOp, RegWrite;
   logic [1:0]  ResultSrc;
   logic [31:0] ImmExt, rd1, rd2, pc_out, a0;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;

   logic        b_in_valid, b_in_ready, b_flush, b_wb_en, b_ex_ready, b_out_valid;
   logic [31:0] b_instr, b_pc_in, b_wb_data;
   logic [3:0]  b_wb_addr;
   logic [2:0]  b_ALUctrl;
   logic        b_ALUSrc, b_MemWrite, b_Branch, b_Jump, b_branch_neg, b_PcOp, b_RegWrite;
   logic [1:0]  b_ResultSrc;
   logic [31:0] b_ImmExt, b_rd1, b_rd2, b_pc_out, b_a0;
   logic [3:0]  b_rs1_addr, b_rs2_addr, b_rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   decode_stage_pipe #(.DATA_WIDTH(32), .REG_COUNT(32), .A0_IDX(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .pc_in(pc_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .out_valid(out_valid), .ALUctrl(ALUctrl), .ALUSrc(ALUSrc),
      .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .branch_neg(branch_neg),
      .PcOp(PcOp), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ImmExt(ImmExt),
      .rd1(rd1), .rd2(rd2), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .pc_out(pc_out), .a0(a0)
   );

   decode_stage_pipe #(.DATA_WIDTH(32), .REG_COUNT(16), .A0_IDX(10)) dut16 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
      .pc_in(b_pc_in), .flush(b_flush), .wb_en(b_wb_en), .wb_addr(b_wb_addr),
      .wb_data(b_wb_data), .ex_ready(b_ex_ready), .out_valid(b_out_valid),
      .ALUctrl(b_ALUctrl), .ALUSrc(b_ALUSrc), .MemWrite(b_MemWrite), .Branch(b_Branch),
      .Jump(b_Jump), .branch_neg(b_branch_neg), .PcOp(b_PcOp), .RegWrite(b_RegWrite),
      .ResultSrc(b_ResultSrc), .ImmExt(b_ImmExt), .rd1(b_rd1), .rd2(b_rd2),
      .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr), .rd_addr(b_rd_addr),
      .pc_out(b_pc_out), .a0(b_a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  alu;
      logic [6:0]  ctl;     // {ALUSrc,MemWrite,Branch,Jump,branch_neg,PcOp,RegWrite}
      logic [1:0]  res;
      logic [31:0] imm;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  rd;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wb(input logic [4:0] addr, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_addr = addr;
      wb_data = data;
      tick();
      wb_en   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h40208233, 32'h200, 3'b001, 7'b0000001, 2'b00, 32'h00000402, 32'h1000,     32'h22,       5'd4};
      vecs[1] = '{32'hFFC18293, 32'h204, 3'b000, 7'b1000001, 2'b00, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'h0,        5'd5};
      vecs[2] = '{32'h0080A303, 32'h208, 3'b000, 7'b1000001, 2'b01, 32'h00000008, 32'h1000,     32'h0,        5'd6};
      vecs[3] = '{32'h0020A623, 32'h20C, 3'b000, 7'b1100000, 2'b00, 32'h0000000C, 32'h1000,     32'h22,       5'd12};
      vecs[4] = '{32'hFE209CE3, 32'h210, 3'b001, 7'b0010100, 2'b00, 32'hFFFFFFF8, 32'h1000,     32'h22,       5'd25};
      vecs[5] = '{32'h010000EF, 32'h214, 3'b000, 7'b0001001, 2'b10, 32'h00000010, 32'h0,        32'h0,        5'd1};
      vecs[6] = '{32'h123453B7, 32'h218, 3'b000, 7'b0000001, 2'b11, 32'h12345000, 32'h0,        32'hFFFFFFF0, 5'd7};
      vecs[7] = '{32'h00008067, 32'h21C, 3'b000, 7'b1001011, 2'b10, 32'h00000000, 32'h1000,     32'h0,        5'd0};
      vecs[8] = '{32'h0030F433, 32'h220, 3'b010, 7'b0000001, 2'b00, 32'h00000003, 32'h1000,     32'hFFFFFFF0, 5'd8};

      b_in_valid = 1'b0; b_instr = '0; b_pc_in = '0; b_flush = 1'b0;
      b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0; b_ex_ready = 1'b1;

      // Reset with valid input, flush and a writeback all pending.
      rst = 1'b1; in_valid = 1'b1; instr = 32'h00528533; pc_in = 32'h40;
      flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h55; ex_ready = 1'b1;
      tick();
      tick();
      check("rst out_valid", {63'd0, out_valid}, 64'd0);
      check("rst rd1", {32'd0, rd1}, 64'd0);
      check("rst ImmExt", {32'd0, ImmExt}, 64'd0);
      check("rst pc_out", {32'd0, pc_out}, 64'd0);
      check("rst ctl", {57'd0, ALUSrc, MemWrite, Branch, Jump, branch_neg, PcOp, RegWrite}, 64'd0);
      check("rst a0", {32'd0, a0}, 64'd0);
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
      #1;
      check("post-rst in_ready", {63'd0, in_ready}, 64'd1);
      $display("reset sequence done");

      // Writeback to x5 coincident with decoding add x10,x5,x5.
      in_valid = 1'b1; instr = 32'h00528533; pc_in = 32'h100;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      #1;
      check("bypass in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0; wb_en = 1'b0;
      check("bypass out_valid", {63'd0, out_valid}, 64'd1);
      check("bypass rd1", {32'd0, rd1}, 64'hDEADBEEF);
      check("bypass rd2", {32'd0, rd2}, 64'hDEADBEEF);
      check("bypass rd_addr", {59'd0, rd_addr}, 64'd10);
      check("bypass RegWrite", {63'd0, RegWrite}, 64'd1);
      check("bypass pc_out", {32'd0, pc_out}, 64'h100);
      $display("txn add x10,x5,x5 rd1=0x%0h rd2=0x%0h", rd1, rd2);
      wb(5'd10, 32'h1234);
      check("a0 after wb", {32'd0, a0}, 64'h1234);
      check("idle out_valid", {63'd0, out_valid}, 64'd0);
      $display("txn wb x10 a0=0x%0h", a0);

      wb(5'd1, 32'h1000);
      wb(5'd2, 32'h22);
      wb(5'd3, 32'hFFFFFFF0);

      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; instr = vecs[i].instr; pc_in = vecs[i].pc; ex_ready = 1'b1;
         tick();
         check($sformatf("v%0d out_valid", i), {63'd0, out_valid}, 64'd1);
         check($sformatf("v%0d ALUctrl", i), {61'd0, ALUctrl}, {61'd0, vecs[i].alu});
         check($sformatf("v%0d ctl", i),
               {57'd0, ALUSrc, MemWrite, Branch, Jump, branch_neg, PcOp, RegWrite},
               {57'd0, vecs[i].ctl});
         check($sformatf("v%0d ResultSrc", i), {62'd0, ResultSrc}, {62'd0, vecs[i].res});
         check($sformatf("v%0d ImmExt", i), {32'd0, ImmExt}, {32'd0, vecs[i].imm});
         check($sformatf("v%0d rd1", i), {32'd0, rd1}, {32'd0, vecs[i].r1});
         check($sformatf("v%0d rd2", i), {32'd0, rd2}, {32'd0, vecs[i].r2});
         check($sformatf("v%0d rd_addr", i), {59'd0, rd_addr}, {59'd0, vecs[i].rd});
         check($sformatf("v%0d pc_out", i), {32'd0, pc_out}, {32'd0, vecs[i].pc});
         $display("vec %0d instr=0x%08h imm=0x%0h rd1=0x%0h rd2=0x%0h", i, vecs[i].instr, ImmExt, rd1, rd2);
      end

      // Load-use: lw x6 followed by add x7,x6,x2 gets exactly one bubble.
      instr = 32'h0000A303; pc_in = 32'h300;
      tick();
      check("lu lw ResultSrc", {62'd0, ResultSrc}, 64'd1);
      instr = 32'h002303B3; pc_in = 32'h304;
      #1;
      check("lu in_ready stall", {63'd0, in_ready}, 64'd0);
      tick();
      check("lu bubble out_valid", {63'd0, out_valid}, 64'd0);
      check("lu in_ready release", {63'd0, in_ready}, 64'd1);
      tick();
      check("lu add out_valid", {63'd0, out_valid}, 64'd1);
      check("lu add rd_addr", {59'd0, rd_addr}, 64'd7);
      check("lu add rs1_addr", {59'd0, rs1_addr}, 64'd6);
      $display("txn load-use add issued after one bubble");

      // Load to x0 never causes a bubble.
      instr = 32'h0000A003; pc_in = 32'h308;
      tick();
      instr = 32'h002003B3; pc_in = 32'h30C;
      #1;
      check("lu x0 in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("lu x0 out_valid", {63'd0, out_valid}, 64'd1);
      check("lu x0 pc_out", {32'd0, pc_out}, 64'h30C);
      $display("txn load x0 no bubble");

      // EX stall for three cycles with a waiting instruction.
      instr = 32'h00500493; pc_in = 32'h310; ex_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d in_ready", c), {63'd0, in_ready}, 64'd0);
         tick();
         check($sformatf("stall%0d out_valid", c), {63'd0, out_valid}, 64'd1);
         check($sformatf("stall%0d rd_addr", c), {59'd0, rd_addr}, 64'd7);
         check($sformatf("stall%0d pc_out", c), {32'd0, pc_out}, 64'h30C);
         $display("txn stall cycle %0d", c);
      end
      ex_ready = 1'b1;
      #1;
      check("stall release in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("stall next rd_addr", {59'd0, rd_addr}, 64'd9);
      check("stall next ImmExt", {32'd0, ImmExt}, 64'd5);
      $display("txn addi x9 captured after stall");

      // Flush while stalled: input consumed, never reaches the output.
      ex_ready = 1'b0; instr = 32'h0030F433; pc_in = 32'h999; flush = 1'b1;
      #1;
      check("flush in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
      check("flush out_valid", {63'd0, out_valid}, 64'd0);
      tick();
      check("flush out_valid later", {63'd0, out_valid}, 64'd0);
      $display("txn flush");

      // Writes to x0 are dropped, including the same-cycle bypass path.
      wb(5'd0, 32'hFFFFFFFF);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      in_valid = 1'b1; instr = 32'h000000B3; pc_in = 32'h400;
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      check("x0 rd1", {32'd0, rd1}, 64'd0);
      check("x0 rd2", {32'd0, rd2}, 64'd0);
      check("x0 out_valid", {63'd0, out_valid}, 64'd1);
      $display("txn add x1,x0,x0 rd1=0x%0h rd2=0x%0h", rd1, rd2);

      // 16-entry register file instance.
      b_wb_en = 1'b1; b_wb_addr = 4'd15; b_wb_data = 32'hCAFEF00D;
      tick();
      b_wb_en = 1'b0;
      b_in_valid = 1'b1; b_instr = 32'h000780B3; b_pc_in = 32'h500;
      tick();
      b_in_valid = 1'b0;
      check("r16 out_valid", {63'd0, b_out_valid}, 64'd1);
      check("r16 rd1", {32'd0, b_rd1}, 64'hCAFEF00D);
      check("r16 rs1_addr", {60'd0, b_rs1_addr}, 64'd15);
      check("r16 rd2", {32'd0, b_rd2}, 64'd0);
      $display("txn reg16 rd1=0x%0h", b_rd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
